// File: rtl/dual_port_sram_16bit.sv
// rtl/dual_port_sram_16bit.sv - true dual-port 256x16 synchronous SRAM, read-first, port A wins write collisions
module dual_port_sram_16bit #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic [DATA_WIDTH-1:0] Port_A_Data_In,
    input  logic [ADDR_WIDTH-1:0] Port_A_Address_In,
    output logic [DATA_WIDTH-1:0] Port_A_Data_Out,
    input  logic                  Port_A_Write_Enable,
    input  logic                  Port_A_Read_Enable,
    input  logic [DATA_WIDTH-1:0] Port_B_Data_In,
    input  logic [ADDR_WIDTH-1:0] Port_B_Address_In,
    output logic [DATA_WIDTH-1:0] Port_B_Data_Out,
    input  logic                  Port_B_Write_Enable,
    input  logic                  Port_B_Read_Enable
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Port B's write is suppressed when port A writes the same word this edge.
    logic b_write_blocked;
    assign b_write_blocked = Port_A_Write_Enable &&
                             (Port_A_Address_In == Port_B_Address_In);

    // Storage update: reset clears every word so no location is ever undefined.
    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (Port_A_Write_Enable) begin
                mem[Port_A_Address_In] <= Port_A_Data_In;
            end
            if (Port_B_Write_Enable && !b_write_blocked) begin
                mem[Port_B_Address_In] <= Port_B_Data_In;
            end
        end
    end

    // Port A read register: samples pre-edge contents (read-first), holds when idle.
    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            Port_A_Data_Out <= '0;
        end else if (Port_A_Read_Enable) begin
            Port_A_Data_Out <= mem[Port_A_Address_In];
        end
    end

    // Port B read register: samples pre-edge contents (read-first), holds when idle.
    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            Port_B_Data_Out <= '0;
        end else if (Port_B_Read_Enable) begin
            Port_B_Data_Out <= mem[Port_B_Address_In];
        end
    end

endmodule

// File: tb/tb_dual_port_sram_16bit.sv
// tb/tb_dual_port_sram_16bit.sv - table-driven bench for dual_port_sram_16bit
module tb_dual_port_sram_16bit;

    logic        clk;
    logic        rst_n;
    logic [15:0] da, db;
    logic [7:0]  aa, ab;
    logic        wa, ra, wb, rb;
    logic [15:0] qa, qb;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] model [256];

    typedef struct {
        string       name;
        logic        wa;
        logic        ra;
        logic [7:0]  aa;
        logic [15:0] da;
        logic        wb;
        logic        rb;
        logic [7:0]  ab;
        logic [15:0] db;
        logic [15:0] ea;
        logic [15:0] eb;
    } vec_t;

    vec_t vecs [17];

    dual_port_sram_16bit dut (
        .Clk_In              (clk),
        .Reset_In            (rst_n),
        .Port_A_Data_In      (da),
        .Port_A_Address_In   (aa),
        .Port_A_Data_Out     (qa),
        .Port_A_Write_Enable (wa),
        .Port_A_Read_Enable  (ra),
        .Port_B_Data_In      (db),
        .Port_B_Address_In   (ab),
        .Port_B_Data_Out     (qb),
        .Port_B_Write_Enable (wb),
        .Port_B_Read_Enable  (rb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model[i] = 16'h0000;
    endtask

    // Drives one cycle of stimulus, waits for the edge, samples 1 time unit after.
    task automatic drive(input logic w_a, input logic r_a, input logic [7:0] a_a, input logic [15:0] d_a,
                         input logic w_b, input logic r_b, input logic [7:0] a_b, input logic [15:0] d_b);
        wa = w_a; ra = r_a; aa = a_a; da = d_a;
        wb = w_b; rb = r_b; ab = a_b; db = d_b;
        @(posedge clk);
        #1;
        if (w_a) model[a_a] = d_a;
        if (w_b && !(w_a && a_a == a_b)) model[a_b] = d_b;
        wa = 1'b0; ra = 1'b0; wb = 1'b0; rb = 1'b0;
    endtask

    initial begin
        logic [7:0]  sa, sb;
        logic [15:0] sda, sdb;

        rst_n = 1'b0;
        wa = 0; ra = 0; wb = 0; rb = 0;
        aa = 0; ab = 0; da = 0; db = 0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("reset_out_a", qa, 16'h0000);
        check("reset_out_b", qb, 16'h0000);

        // Populate and read so outputs are nonzero before the mid-cycle reset.
        drive(1, 0, 8'h24, 16'hDEAD, 1, 0, 8'h25, 16'hBEEF);
        drive(0, 1, 8'h24, 16'h0, 0, 1, 8'h25, 16'h0);
        check("pre_reset_a", qa, 16'hDEAD);
        check("pre_reset_b", qb, 16'hBEEF);

        // Asynchronous reset mid-cycle with reads requested on both ports.
        #3;
        ra = 1; rb = 1; aa = 8'h24; ab = 8'h25;
        rst_n = 1'b0;
        #1;
        check("async_reset_a", qa, 16'h0000);
        check("async_reset_b", qb, 16'h0000);
        wa = 1; da = 16'h7777; wb = 1; db = 16'h8888;
        @(posedge clk);
        #1;
        check("reset_held_a", qa, 16'h0000);
        check("reset_held_b", qb, 16'h0000);
        rst_n = 1'b1;
        wa = 0; wb = 0; ra = 0; rb = 0;
        clear_model();

        drive(0, 1, 8'h24, 16'h0, 0, 1, 8'h25, 16'h0);
        check("cleared_24", qa, 16'h0000);
        check("cleared_25", qb, 16'h0000);

        vecs[0]  = '{"wr_basic",     1'b1, 1'b0, 8'h81, 16'h3524, 1'b1, 1'b0, 8'h0D, 16'h5663, 16'h0000, 16'h0000};
        vecs[1]  = '{"rd_basic",     1'b0, 1'b1, 8'h81, 16'h0000, 1'b0, 1'b1, 8'h0D, 16'h0000, 16'h3524, 16'h5663};
        vecs[2]  = '{"rd_cross",     1'b0, 1'b1, 8'h0D, 16'h0000, 1'b0, 1'b1, 8'h81, 16'h0000, 16'h5663, 16'h3524};
        vecs[3]  = '{"rd_again",     1'b0, 1'b1, 8'h81, 16'h0000, 1'b0, 1'b1, 8'h0D, 16'h0000, 16'h3524, 16'h5663};
        vecs[4]  = '{"hold_1",       1'b1, 1'b0, 8'h30, 16'h1234, 1'b1, 1'b0, 8'h31, 16'h4321, 16'h3524, 16'h5663};
        vecs[5]  = '{"hold_2",       1'b1, 1'b0, 8'h81, 16'h9999, 1'b1, 1'b0, 8'h0D, 16'h6666, 16'h3524, 16'h5663};
        vecs[6]  = '{"hold_3",       1'b1, 1'b0, 8'h32, 16'h0F0F, 1'b0, 1'b0, 8'h33, 16'h0000, 16'h3524, 16'h5663};
        vecs[7]  = '{"wr_collide",   1'b1, 1'b0, 8'h10, 16'hAAAA, 1'b1, 1'b0, 8'h10, 16'hBBBB, 16'h3524, 16'h5663};
        vecs[8]  = '{"rd_collide",   1'b0, 1'b1, 8'h10, 16'h0000, 1'b0, 1'b1, 8'h10, 16'h0000, 16'hAAAA, 16'hAAAA};
        vecs[9]  = '{"wr_1111",      1'b1, 1'b0, 8'h20, 16'h1111, 1'b0, 1'b0, 8'h00, 16'h0000, 16'hAAAA, 16'hAAAA};
        vecs[10] = '{"xport_rdfirst",1'b1, 1'b0, 8'h20, 16'h2222, 1'b0, 1'b1, 8'h20, 16'h0000, 16'hAAAA, 16'h1111};
        vecs[11] = '{"xport_newval", 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h20, 16'h0000, 16'hAAAA, 16'h2222};
        vecs[12] = '{"same_rdfirst", 1'b1, 1'b1, 8'h20, 16'h3333, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h2222, 16'h2222};
        vecs[13] = '{"same_newval",  1'b0, 1'b1, 8'h20, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h3333, 16'h2222};
        vecs[14] = '{"rd_hold_wr",   1'b0, 1'b1, 8'h31, 16'h0000, 1'b0, 1'b1, 8'h30, 16'h0000, 16'h4321, 16'h1234};
        vecs[15] = '{"b_wr_a_rd",    1'b0, 1'b1, 8'h40, 16'h0000, 1'b1, 1'b0, 8'h40, 16'h5555, 16'h0000, 16'h1234};
        vecs[16] = '{"a_rd_new",     1'b0, 1'b1, 8'h40, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h5555, 16'h1234};

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].wa, vecs[i].ra, vecs[i].aa, vecs[i].da,
                  vecs[i].wb, vecs[i].rb, vecs[i].ab, vecs[i].db);
            check({vecs[i].name, "_a"}, qa, vecs[i].ea);
            check({vecs[i].name, "_b"}, qb, vecs[i].eb);
        end

        // Random soak: write on both ports, then cross read-back against the model.
        for (int i = 0; i < 20; i++) begin
            sa  = 8'($urandom_range(0, 255));
            sb  = (i % 4 == 0) ? sa : 8'($urandom_range(0, 255));
            sda = 16'($urandom);
            sdb = 16'($urandom);
            drive(1, 0, sa, sda, 1, 0, sb, sdb);
            drive(0, 1, sb, 16'h0, 0, 1, sa, 16'h0);
            check($sformatf("soak%0d_a", i), qa, model[sb]);
            check($sformatf("soak%0d_b", i), qb, model[sa]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_port_sram_16bit.md
Name:
dual_port_sram_16bit

Overview:
- True dual-port synchronous SRAM: 256 words x 16 bits.
- Two independent read/write ports (A, B) share one clock and one storage array.
- Used as a general-purpose on-chip buffer wherever two agents need concurrent access to shared data.

Parameters:
- DATA_WIDTH, 16, word width in bits.
- ADDR_WIDTH, 8, address width in bits.
- DEPTH, 256, number of words; must equal 2**ADDR_WIDTH.

Ports:
- Clk_In  input  1  single clock; all state changes on rising edge.
- Reset_In  input  1  reset, asynchronous, active-low.
- Port_A_Data_In  input  16  port A write data.
- Port_A_Address_In  input  8  port A word address.
- Port_A_Data_Out  output  16  port A registered read data.
- Port_A_Write_Enable  input  1  port A write strobe, active-high.
- Port_A_Read_Enable  input  1  port A read strobe, active-high.
- Port_B_Data_In  input  16  port B write data.
- Port_B_Address_In  input  8  port B word address.
- Port_B_Data_Out  output  16  port B registered read data.
- Port_B_Write_Enable  input  1  port B write strobe, active-high.
- Port_B_Read_Enable  input  1  port B read strobe, active-high.

Behaviour:
- Reset (Reset_In = 0, asynchronous, no clock needed):
  - Port_A_Data_Out = 16'h0000 and Port_B_Data_Out = 16'h0000 immediately.
  - All 256 memory words cleared to 16'h0000.
  - Writes and reads are ignored while reset is asserted.
  - Deassertion takes effect from the next rising edge.
- Write: on a rising edge with WE = 1, mem[addr] <= Data_In. Visible to either port's read from the next edge.
- Read: on a rising edge with RE = 1, Data_Out <= mem[addr] (value before this edge's writes). Latency is one cycle; data is valid after the edge that samples RE.
- When RE = 0, Data_Out holds its last value; it never returns to zero except on reset.
- Same port, WE = 1 and RE = 1 together: the write occurs and the read returns the old (pre-write) contents (read-first).
- Cross-port read/write to the same address in the same cycle: the reader gets the old data (read-first). The new data is visible one cycle later.
- Both ports write the same address in the same cycle: port A's data is stored and port B's write is dropped. Writes to different addresses both complete.
- Both ports read the same address: both receive the same data.
- Addresses are full 8-bit, so there is no out-of-range access and no wrap-around logic.
- All control inputs are level-sampled per edge; there is no handshake and no backpressure. One operation per port per cycle, at full throughput.
- No X propagation after reset: every location holds a defined value.

Test Plan:
- Reset check: drive Reset_In = 0 mid-cycle with RE = 1 on both ports -> both outputs 16'h0000 immediately. After release, read of address 8'h24 -> 16'h0000.
- Basic write/read:
  - Cycle 1: A writes 16'h3524 to 8'h81; B writes 16'h5663 to 8'h0D.
  - Cycle 2: RE = 1 on both ports, same addresses.
  - Required: Port_A_Data_Out = 16'h3524 and Port_B_Data_Out = 16'h5663 after the cycle-2 edge.
  - Cross-read: A reads 8'h0D -> 16'h5663.
- Hold: after a read returns 16'h3524, deassert RE for 3 cycles while writing other addresses -> output stays 16'h3524.
- Write collision:
  - A writes 16'hAAAA and B writes 16'hBBBB to 8'h10 in the same cycle.
  - A next-cycle read of 8'h10 from either port -> 16'hAAAA.
- Read-first behaviour:
  - mem[8'h20] = 16'h1111. In one cycle, A writes 16'h2222 to 8'h20 while B reads 8'h20 -> B sees 16'h1111.
  - The next B read of 8'h20 -> 16'h2222.
  - Same-port WE + RE on A gives the same result.
- Random soak: 20 iterations of random write (both ports) then read-back (both ports) -> outputs match a scoreboard model that applies the A-wins collision rule.
